// File: rtl/dec_pkg.sv
// Shared types and constants for the registered one-hot decoder/sequencer.
package dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_onehot.sv
// Combinational AW-to-2^AW one-hot decoder; all-zero output when en is low.
module dec_onehot #(
  parameter  int unsigned AW   = 2,
  localparam int unsigned NOUT = 1 << AW
) (
  input  logic            en,
  input  logic [AW-1:0]   addr,
  output logic [NOUT-1:0] onehot
);

  // Single bit set at addr, or nothing when disabled.
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered one-hot select generator: DIRECT decodes an accepted address,
// SCAN sweeps all lines with a programmable dwell.
// Build option: DEC_SCAN_EN enables SCAN mode, the dwell counter and wrap pulse.
module dec_onehot_seq #(
  parameter  int unsigned AW   = 2,
  parameter  int unsigned DW   = 4,
  localparam int unsigned NOUT = 1 << AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [AW-1:0]   addr_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   dwell,
  output logic [NOUT-1:0] dout,
  output logic            out_valid,
  output logic [AW-1:0]   cur_addr,
  output logic            wrap
);
  import dec_pkg::*;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              on_d;
  logic              vld_q;
  logic [NOUT-1:0]   dout_q, dout_d;
  logic              wrap_q, wrap_d;
  logic              mode_int;
  logic              accept;

`ifdef DEC_SCAN_EN
  logic [DW-1:0]     cnt_q, cnt_d;
  assign mode_int = mode;
`else
  logic              unused_cfg;
  assign mode_int   = MODE_DIRECT;
  assign unused_cfg = ^{mode, dwell};
`endif

  // Ready depends only on enable and mode, never on state.
  assign in_ready = en & (mode_int == MODE_DIRECT);
  assign accept   = in_valid & in_ready;

  // Next-state, next select index and wrap pulse.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    on_d    = vld_q;
    wrap_d  = 1'b0;
`ifdef DEC_SCAN_EN
    cnt_d   = cnt_q;
`endif
    if (!en) begin
      state_d = ST_IDLE;
      on_d    = 1'b0;
    end else if (mode_int == MODE_SCAN) begin
`ifdef DEC_SCAN_EN
      if (state_q != ST_SCAN) begin
        state_d = ST_SCAN;
        addr_d  = '0;
        on_d    = 1'b1;
        cnt_d   = '0;
      end else if (cnt_q >= dwell) begin
        cnt_d   = '0;
        addr_d  = AW'(addr_q + AW'(1));
        on_d    = 1'b1;
        wrap_d  = (addr_q == AW'(NOUT - 1));
      end else begin
        cnt_d   = DW'(cnt_q + DW'(1));
      end
`endif
    end else begin
      state_d = ST_DIRECT;
      if (accept) begin
        addr_d = addr_in;
        on_d   = 1'b1;
      end
    end
  end

  dec_onehot #(.AW(AW)) u_dec (
    .en     (on_d),
    .addr   (addr_d),
    .onehot (dout_d)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
      wrap_q  <= 1'b0;
`ifdef DEC_SCAN_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vld_q   <= on_d;
      dout_q  <= dout_d;
      wrap_q  <= wrap_d;
`ifdef DEC_SCAN_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign out_valid = vld_q;
  assign cur_addr  = addr_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Self-checking bench for dec_onehot_seq: AW=2 and AW=3 instances,
// scoreboard queues of expected registered outputs per clock.
module tb_dec_onehot_seq;

  typedef struct packed {
    logic [3:0] dout;
    logic       vld;
    logic [1:0] cur;
    logic       wrap;
  } obs_a_t;

  typedef struct packed {
    logic [7:0] dout;
    logic       vld;
    logic [2:0] cur;
    logic       wrap;
  } obs_b_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_en = 1'b0, a_mode = 1'b0, a_valid = 1'b0;
  logic [1:0] a_addr = '0;
  logic [3:0] a_dwell = '0;
  logic       a_ready, a_vld, a_wrap;
  logic [3:0] a_dout;
  logic [1:0] a_cur;

  logic       b_en = 1'b0, b_mode = 1'b0, b_valid = 1'b0;
  logic [2:0] b_addr = '0;
  logic [3:0] b_dwell = '0;
  logic       b_ready, b_vld, b_wrap;
  logic [7:0] b_dout;
  logic [2:0] b_cur;

  dec_onehot_seq #(.AW(2), .DW(4)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .addr_in(a_addr),
    .in_valid(a_valid), .in_ready(a_ready), .dwell(a_dwell), .dout(a_dout),
    .out_valid(a_vld), .cur_addr(a_cur), .wrap(a_wrap)
  );

  dec_onehot_seq #(.AW(3), .DW(4)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .addr_in(b_addr),
    .in_valid(b_valid), .in_ready(b_ready), .dwell(b_dwell), .dout(b_dout),
    .out_valid(b_vld), .cur_addr(b_cur), .wrap(b_wrap)
  );

  int     checks = 0;
  int     failures = 0;
  obs_a_t exp_a_q[$];
  obs_b_t exp_b_q[$];
  obs_a_t got_a, exp_a;
  obs_b_t got_b, exp_b;

  function automatic obs_a_t mk_a(input int line, input bit vld, input bit wr);
    obs_a_t r;
    r.dout = vld ? 4'(1 << line) : 4'b0;
    r.vld  = vld;
    r.cur  = 2'(line);
    r.wrap = wr;
    return r;
  endfunction

  function automatic obs_b_t mk_b(input int line, input bit vld, input bit wr);
    obs_b_t r;
    r.dout = vld ? 8'(1 << line) : 8'b0;
    r.vld  = vld;
    r.cur  = 3'(line);
    r.wrap = wr;
    return r;
  endfunction

  // Advance one clock and capture both instances 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
    got_a = {a_dout, a_vld, a_cur, a_wrap};
    got_b = {b_dout, b_vld, b_cur, b_wrap};
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    got_a = {a_dout, a_vld, a_cur, a_wrap};
    checks++;
    if (got_a !== '0) begin
      failures++;
      $display("FAIL reset_async: got %b want %b", got_a, obs_a_t'(0));
    end
    tick();
    tick();
    @(negedge clk) rst = 1'b0;
    exp_a_q.push_back(mk_a(0, 0, 0));
    tick();
    exp_a = exp_a_q.pop_front();
    checks++;
    if (got_a !== exp_a) begin
      failures++;
      $display("FAIL reset_release: got %b want %b", got_a, exp_a);
    end
  endtask

  task automatic test_direct;
    a_en = 1'b1; a_mode = 1'b0; a_valid = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL direct_ready: got %b want 1", a_ready);
    end
    exp_a_q.push_back(mk_a(0, 0, 0));
    for (int a = 0; a < 4; a++) exp_a_q.push_back(mk_a(a, 1, 0));
    exp_a_q.push_back(mk_a(3, 1, 0));
    exp_a_q.push_back(mk_a(3, 1, 0));
    for (int k = 0; k < 7; k++) begin
      if (k >= 1 && k <= 4) begin
        a_addr = 2'(k - 1);
        a_valid = 1'b1;
      end else begin
        a_valid = 1'b0;
      end
      tick();
      a_valid = 1'b0;
      exp_a = exp_a_q.pop_front();
      checks++;
      if (got_a !== exp_a) begin
        failures++;
        $display("FAIL direct[%0d]: got %b want %b", k, got_a, exp_a);
      end
    end
  endtask

  task automatic test_direct_aw3;
    int seq [8] = '{5, 0, 7, 3, 6, 1, 4, 2};
    b_en = 1'b1; b_mode = 1'b0; b_valid = 1'b0;
    exp_b_q.push_back(mk_b(0, 0, 0));
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_b = exp_b_q.pop_front();
      checks++;
      if (got_b !== exp_b) begin
        failures++;
        $display("FAIL direct_aw3[%0d]: got %b want %b", i, got_b, exp_b);
      end
      b_addr = 3'(seq[i]);
      b_valid = 1'b1;
      exp_b_q.push_back(mk_b(seq[i], 1, 0));
      tick();
    end
    b_valid = 1'b0;
    exp_b = exp_b_q.pop_front();
    checks++;
    if (got_b !== exp_b) begin
      failures++;
      $display("FAIL direct_aw3_last: got %b want %b", got_b, exp_b);
    end
  endtask

  task automatic test_en_drop;
    a_en = 1'b0; a_valid = 1'b1; a_addr = 2'd1;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_ready: got %b want 0", a_ready);
    end
    exp_a_q.push_back(mk_a(3, 0, 0));
    exp_a_q.push_back(mk_a(3, 0, 0));
    exp_a_q.push_back(mk_a(2, 1, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_a = exp_a_q.pop_front();
      checks++;
      if (got_a !== exp_a) begin
        failures++;
        $display("FAIL en_drop[%0d]: got %b want %b", k, got_a, exp_a);
      end
      a_en = 1'b1;
      a_valid = (k == 1);
      a_addr = 2'd2;
    end
    a_valid = 1'b0;
  endtask

`ifndef DEC_SCAN_EN
  task automatic test_mode_ignored;
    a_mode = 1'b1; a_valid = 1'b1; a_addr = 2'd1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL noscan_ready: got %b want 1", a_ready);
    end
    for (int k = 0; k < 4; k++) exp_a_q.push_back(mk_a(1, 1, 0));
    for (int k = 0; k < 4; k++) begin
      tick();
      a_valid = 1'b0;
      exp_a = exp_a_q.pop_front();
      checks++;
      if (got_a !== exp_a) begin
        failures++;
        $display("FAIL noscan[%0d]: got %b want %b", k, got_a, exp_a);
      end
    end
  endtask
`else
  task automatic test_scan;
    a_mode = 1'b1; a_dwell = 4'd2; a_valid = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      failures++;
      $display("FAIL scan_ready: got %b want 0", a_ready);
    end
    for (int k = 0; k < 19; k++) exp_a_q.push_back(mk_a((k / 3) % 4, 1, k == 12));
    for (int k = 0; k < 19; k++) begin
      tick();
      exp_a = exp_a_q.pop_front();
      checks++;
      if (got_a !== exp_a) begin
        failures++;
        $display("FAIL scan[%0d]: got %b want %b", k, got_a, exp_a);
      end
    end
  endtask

  task automatic test_scan_to_direct;
    a_mode = 1'b0; a_valid = 1'b0;
    exp_a_q.push_back(mk_a(2, 1, 0));
    exp_a_q.push_back(mk_a(2, 1, 0));
    exp_a_q.push_back(mk_a(1, 1, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_a = exp_a_q.pop_front();
      checks++;
      if (got_a !== exp_a) begin
        failures++;
        $display("FAIL scan_to_direct[%0d]: got %b want %b", k, got_a, exp_a);
      end
      a_valid = (k == 1);
      a_addr = 2'd1;
    end
    a_valid = 1'b0;
  endtask

  task automatic test_scan_aw3;
    b_mode = 1'b1; b_dwell = 4'd0; b_valid = 1'b0;
    for (int k = 0; k < 17; k++) exp_b_q.push_back(mk_b(k % 8, 1, (k > 0) && (k % 8 == 0)));
    for (int k = 0; k < 17; k++) begin
      tick();
      exp_b = exp_b_q.pop_front();
      checks++;
      if (got_b !== exp_b) begin
        failures++;
        $display("FAIL scan_aw3[%0d]: got %b want %b", k, got_b, exp_b);
      end
    end
  endtask
`endif

  task automatic test_reset_mid;
    a_mode = 1'b1; a_dwell = 4'd1;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    got_a = {a_dout, a_vld, a_cur, a_wrap};
    got_b = {b_dout, b_vld, b_cur, b_wrap};
    checks++;
    if (got_a !== '0) begin
      failures++;
      $display("FAIL reset_mid_a: got %b want %b", got_a, obs_a_t'(0));
    end
    checks++;
    if (got_b !== '0) begin
      failures++;
      $display("FAIL reset_mid_b: got %b want %b", got_b, obs_b_t'(0));
    end
    @(negedge clk);
    rst = 1'b0; a_mode = 1'b0; a_valid = 1'b0;
    exp_a_q.push_back(mk_a(0, 0, 0));
    exp_a_q.push_back(mk_a(3, 1, 0));
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_a = exp_a_q.pop_front();
      checks++;
      if (got_a !== exp_a) begin
        failures++;
        $display("FAIL reset_mid_post[%0d]: got %b want %b", k, got_a, exp_a);
      end
      a_valid = 1'b1;
      a_addr = 2'd3;
    end
    a_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_direct();
    test_direct_aw3();
    test_en_drop();
`ifndef DEC_SCAN_EN
    test_mode_ignored();
`else
    test_scan();
    test_scan_to_direct();
    test_scan_aw3();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_onehot_seq.md
# dec_onehot_seq

Parametrised, registered AW-to-2^AW one-hot decoder with enable, valid/ready address input and an optional self-sequencing scan mode. Generation-two successor of the team's combinational 2-to-4 decoder. Used as a select/strobe generator for banked peripherals: either driven directly by an address source or free-running to sweep all select lines with a programmable dwell. Outputs are registered, so downstream sees glitch-free one-hot selects.

## Interface
- AW, 2: address width; NOUT = 2**AW select lines (derived localparam).
- DW, 4: dwell field width.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; low forces IDLE and all selects low.
- mode  in  1  0 = DIRECT, 1 = SCAN.
- addr_in  in  AW  address to decode in DIRECT.
- in_valid  in  1  addr_in valid.
- in_ready  out  1  combinational: en & (mode==0); no state dependency.
- dwell  in  DW  SCAN: each select held dwell+1 cycles.
- dout  out  NOUT  registered one-hot select (or all-zero).
- out_valid  out  1  registered; high whenever dout is non-zero.
- cur_addr  out  AW  registered index of the asserted select line.
- wrap  out  1  registered one-cycle pulse on SCAN wrap NOUT-1 -> 0.

## Operation
- States: IDLE, DIRECT, SCAN. Reset -> IDLE; dout=0, out_valid=0, cur_addr=0, wrap=0, dwell counter=0.
- en=0 in any state: next cycle IDLE, dout=0, out_valid=0, wrap=0; cur_addr holds.
- IDLE: en & mode==0 -> DIRECT; en & mode==1 -> SCAN, cur_addr=0, dout=1<<0, counter=0.
- DIRECT: on in_valid & in_ready, next cycle dout = 1<<addr_in, cur_addr = addr_in, out_valid=1. No accept: dout holds. Entered from IDLE with no accept: dout stays 0.
- DIRECT & mode==1 -> SCAN restarting at cur_addr=0, counter=0.
- SCAN: counter increments each cycle; when counter==dwell, counter=0 and cur_addr=cur_addr+1 modulo NOUT, dout follows. dwell is sampled live; lowering dwell below current counter causes step on next cycle (counter>=dwell compare).
- Wrap: step from NOUT-1 to 0 sets wrap=1 for exactly the cycle dout first shows line 0.
- SCAN & mode==0 -> DIRECT; dout/cur_addr hold last scanned value until an accept. Accept is possible in the same cycle mode drops (in_ready is combinational).
- dout is always one-hot or zero; never more than one bit set.

## Timing
- Accept -> dout: 1 cycle. Back-to-back accepts every cycle allowed.
- SCAN step period: dwell+1 cycles; dwell=0 steps every cycle; full sweep NOUT*(dwell+1) cycles.
- en fall -> dout zero: 1 cycle. en rise -> first select: 1 cycle (SCAN) or accept+1 (DIRECT).
- rst asserted mid-operation: outputs zero immediately (async), state IDLE; release synchronous to clk, first transition on the following edge.

## Configuration
- DEC_SCAN_EN defined: SCAN state, dwell counter and wrap generation present as above.
- Undefined: SCAN state and counter not built; mode treated as 0 internally; in_ready = en; wrap tied 0; dwell ignored. DIRECT behaviour identical.

## Structure
- Package dec_pkg: state enum (IDLE, DIRECT, SCAN), MODE_DIRECT/MODE_SCAN constants.
- Sub-module dec_onehot: parametrised combinational AW-to-NOUT decoder with enable, instantiated once feeding the dout register.

## Test plan
- Reset: rst=1 mid-SCAN -> dout=0, out_valid=0, cur_addr=0, wrap=0 same cycle, IDLE after release.
- DIRECT AW=2: en=1, mode=0, accept addr 0,1,2,3 back-to-back -> dout 0001,0010,0100,1000 each one cycle after accept.
- SCAN AW=2, dwell=2 -> each line held 3 cycles, sweep 12 cycles, wrap=1 single cycle with dout=0001.
- SCAN dwell=0, AW=3 -> dout rotates every cycle through 8 lines; wrap every 8th cycle.
- Mode SCAN->DIRECT while cur_addr=2 -> dout holds 0100 until accept of addr 1 -> 0010 next cycle.
- en dropped during DIRECT with in_valid=1 -> in_ready=0, no accept, dout=0 next cycle; build without DEC_SCAN_EN, mode=1 -> behaves as DIRECT, wrap stays 0.
